env_grid_decay: RTL



---
 rtl/env_grid_decay_pkg.sv | 23 ++
 rtl/env_grid_if.sv | 41 ++++
 rtl/env_grid_decay_row.sv | 80 ++++++++
 rtl/env_grid_decay.sv | 130 +++++++++++++
 4 files changed

// File: rtl/env_grid_decay_pkg.sv
// Shared types and default sizing for the pheromone/sugar environment grid.
// Imported by the interface, the row slice and the top level.
package env_grid_decay_pkg;

  localparam int DEF_PIXELS_X     = 64;
  localparam int DEF_PIXELS_Y     = 48;
  localparam int DEF_SIGNAL_BITS  = 4;
  localparam int DEF_DECAY_PERIOD = 1024;
  localparam int DEF_DECAY_STEP   = 1;

  typedef enum logic [1:0] {
    WM_OVERWRITE = 2'b00,
    WM_DEPOSIT   = 2'b01,
    WM_TAKE      = 2'b10,
    WM_NOP       = 2'b11
  } wm_t;

  typedef enum logic {
    DS_IDLE  = 1'b0,
    DS_SWEEP = 1'b1
  } ds_t;

endpackage

// File: rtl/env_grid_if.sv
// Bundle of the write, lookup, render and evaporation-control signals of the grid.
// The grid itself uses the slave view; the ant/video side uses the master view.
interface env_grid_if #(
  parameter int PIXELS_X    = env_grid_decay_pkg::DEF_PIXELS_X,
  parameter int PIXELS_Y    = env_grid_decay_pkg::DEF_PIXELS_Y,
  parameter int SIGNAL_BITS = env_grid_decay_pkg::DEF_SIGNAL_BITS
);
  localparam int X_BITS = $clog2(PIXELS_X);
  localparam int Y_BITS = $clog2(PIXELS_Y);

  logic                      write_flag;
  env_grid_decay_pkg::wm_t   write_mode;
  logic [X_BITS-1:0]         write_X;
  logic [Y_BITS-1:0]         write_Y;
  logic [SIGNAL_BITS-1:0]    write_signal;
  logic                      write_sugar;
  logic [X_BITS-1:0]         lookup_X;
  logic [Y_BITS-1:0]         lookup_Y;
  logic [SIGNAL_BITS-1:0]    lookup_signal;
  logic                      lookup_sugar;
  logic [X_BITS-1:0]         render_X;
  logic [Y_BITS-1:0]         render_Y;
  logic [SIGNAL_BITS-1:0]    render_signal;
  logic                      render_sugar;
  logic                      decay_en;
  logic                      decay_now;
  logic                      decay_busy;
  logic                      sweep_done;

  modport master (
    output write_flag, write_mode, write_X, write_Y, write_signal, write_sugar,
    output lookup_X, lookup_Y, render_X, render_Y, decay_en, decay_now,
    input  lookup_signal, lookup_sugar, render_signal, render_sugar, decay_busy, sweep_done
  );

  modport slave (
    input  write_flag, write_mode, write_X, write_Y, write_signal, write_sugar,
    input  lookup_X, lookup_Y, render_X, render_Y, decay_en, decay_now,
    output lookup_signal, lookup_sugar, render_signal, render_sugar, decay_busy, sweep_done
  );
endinterface

// File: rtl/env_grid_decay_row.sv
// One row of {signal, sugar} cells: per-column write and evaporation logic plus
// two combinational column read muxes (lookup and render).
module env_row_decay
  import env_grid_decay_pkg::*;
#(
  parameter  int PIXELS_X    = DEF_PIXELS_X,
  parameter  int SIGNAL_BITS = DEF_SIGNAL_BITS,
  parameter  int DECAY_STEP  = DEF_DECAY_STEP,
  localparam int X_BITS      = $clog2(PIXELS_X)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [X_BITS-1:0]      wr_col,
  input  wm_t                    wr_mode,
  input  logic [SIGNAL_BITS-1:0] wr_signal,
  input  logic                   wr_sugar,
  input  logic                   decay,
  input  logic [X_BITS-1:0]      rd_col_a,
  output logic [SIGNAL_BITS-1:0] rd_signal_a,
  output logic                   rd_sugar_a,
  input  logic [X_BITS-1:0]      rd_col_b,
  output logic [SIGNAL_BITS-1:0] rd_signal_b,
  output logic                   rd_sugar_b
);
  localparam logic [SIGNAL_BITS-1:0] STEP  = SIGNAL_BITS'(DECAY_STEP);
  localparam logic [X_BITS:0]        X_LIM = (X_BITS+1)'(PIXELS_X);

  logic [SIGNAL_BITS-1:0] sig_arr [PIXELS_X];
  logic                   sug_arr [PIXELS_X];

  for (genvar gi = 0; gi < PIXELS_X; gi++) begin : g_col
    logic [SIGNAL_BITS-1:0] sig_reg;
    logic                   sug_reg;
    logic                   hit;
    logic [SIGNAL_BITS:0]   sum;

    assign hit = wr_en && (wr_col == X_BITS'(gi));
    assign sum = {1'b0, sig_reg} + {1'b0, wr_signal};

    // A write wins over evaporation and is computed from the undecayed value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sig_reg <= '0;
        sug_reg <= 1'b0;
      end else if (hit) begin
        case (wr_mode)
          WM_OVERWRITE: begin
            sig_reg <= wr_signal;
            sug_reg <= wr_sugar;
          end
          WM_DEPOSIT: sig_reg <= sum[SIGNAL_BITS] ? '1 : sum[SIGNAL_BITS-1:0];
          WM_TAKE:    sug_reg <= 1'b0;
          default:    ;
        endcase
      end else if (decay) begin
        sig_reg <= (sig_reg >= STEP) ? (sig_reg - STEP) : '0;
      end
    end

    assign sig_arr[gi] = sig_reg;
    assign sug_arr[gi] = sug_reg;
  end

  always_comb begin
    rd_signal_a = '0;
    rd_sugar_a  = 1'b0;
    rd_signal_b = '0;
    rd_sugar_b  = 1'b0;
    if ({1'b0, rd_col_a} < X_LIM) begin
      rd_signal_a = sig_arr[rd_col_a];
      rd_sugar_a  = sug_arr[rd_col_a];
    end
    if ({1'b0, rd_col_b} < X_LIM) begin
      rd_signal_b = sig_arr[rd_col_b];
      rd_sugar_b  = sug_arr[rd_col_b];
    end
  end

endmodule

// File: rtl/env_grid_decay.sv
// Environment grid with deposit/take write modes and a periodic row-by-row
// evaporation sweep; holds the sweep FSM, row decode and registered read ports.
module env_grid_decay
  import env_grid_decay_pkg::*;
#(
  parameter  int PIXELS_X     = DEF_PIXELS_X,
  parameter  int PIXELS_Y     = DEF_PIXELS_Y,
  parameter  int SIGNAL_BITS  = DEF_SIGNAL_BITS,
  parameter  int DECAY_PERIOD = DEF_DECAY_PERIOD,
  parameter  int DECAY_STEP   = DEF_DECAY_STEP,
  localparam int X_BITS       = $clog2(PIXELS_X),
  localparam int Y_BITS       = $clog2(PIXELS_Y)
) (
  input logic       newLocClock,
  input logic       RESET_SIM,
  env_grid_if.slave bus
);
  localparam int                    CNT_BITS = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(DECAY_PERIOD - 1);
  localparam logic [Y_BITS-1:0]     ROW_LAST = Y_BITS'(PIXELS_Y - 1);
  localparam logic [Y_BITS-1:0]     ROW_PEN  = Y_BITS'(PIXELS_Y - 2);
  localparam logic [X_BITS:0]       X_LIM    = (X_BITS+1)'(PIXELS_X);
  localparam logic [Y_BITS:0]       Y_LIM    = (Y_BITS+1)'(PIXELS_Y);

  ds_t                    state_reg;
  logic [CNT_BITS-1:0]    cnt_reg;
  logic [Y_BITS-1:0]      row_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [SIGNAL_BITS-1:0] lookup_signal_reg, render_signal_reg;
  logic                   lookup_sugar_reg, render_sugar_reg;

  logic                   write_ok;
  logic [SIGNAL_BITS-1:0] lk_sig [PIXELS_Y];
  logic                   lk_sug [PIXELS_Y];
  logic [SIGNAL_BITS-1:0] rn_sig [PIXELS_Y];
  logic                   rn_sug [PIXELS_Y];

  // Out-of-range and no-op writes never reach a row, so those cells just decay.
  assign write_ok = bus.write_flag && (bus.write_mode != WM_NOP)
                 && ({1'b0, bus.write_X} < X_LIM) && ({1'b0, bus.write_Y} < Y_LIM);

  for (genvar gi = 0; gi < PIXELS_Y; gi++) begin : g_row
    env_row_decay #(
      .PIXELS_X    (PIXELS_X),
      .SIGNAL_BITS (SIGNAL_BITS),
      .DECAY_STEP  (DECAY_STEP)
    ) u_row (
      .clk         (newLocClock),
      .rst_n       (RESET_SIM),
      .wr_en       (write_ok && (bus.write_Y == Y_BITS'(gi))),
      .wr_col      (bus.write_X),
      .wr_mode     (bus.write_mode),
      .wr_signal   (bus.write_signal),
      .wr_sugar    (bus.write_sugar),
      .decay       ((state_reg == DS_SWEEP) && (row_reg == Y_BITS'(gi))),
      .rd_col_a    (bus.lookup_X),
      .rd_signal_a (lk_sig[gi]),
      .rd_sugar_a  (lk_sug[gi]),
      .rd_col_b    (bus.render_X),
      .rd_signal_b (rn_sig[gi]),
      .rd_sugar_b  (rn_sug[gi])
    );
  end

  // done is raised one cycle early so it lines up with the last busy cycle.
  always_ff @(posedge newLocClock or negedge RESET_SIM) begin
    if (!RESET_SIM) begin
      state_reg <= DS_IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        DS_IDLE: begin
          if (bus.decay_now || (cnt_reg == CNT_LAST)) begin
            state_reg <= DS_SWEEP;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end else if (bus.decay_en) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DS_SWEEP: begin
          if (row_reg == ROW_LAST) begin
            state_reg <= DS_IDLE;
            row_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            row_reg  <= row_reg + 1'b1;
            done_reg <= (row_reg == ROW_PEN);
          end
        end
        default: state_reg <= DS_IDLE;
      endcase
    end
  end

  always_ff @(posedge newLocClock or negedge RESET_SIM) begin
    if (!RESET_SIM) begin
      lookup_signal_reg <= '0;
      lookup_sugar_reg  <= 1'b0;
      render_signal_reg <= '0;
      render_sugar_reg  <= 1'b0;
    end else begin
      lookup_signal_reg <= '0;
      lookup_sugar_reg  <= 1'b0;
      render_signal_reg <= '0;
      render_sugar_reg  <= 1'b0;
      if ({1'b0, bus.lookup_Y} < Y_LIM) begin
        lookup_signal_reg <= lk_sig[bus.lookup_Y];
        lookup_sugar_reg  <= lk_sug[bus.lookup_Y];
      end
      if ({1'b0, bus.render_Y} < Y_LIM) begin
        render_signal_reg <= rn_sig[bus.render_Y];
        render_sugar_reg  <= rn_sug[bus.render_Y];
      end
    end
  end

  assign bus.lookup_signal = lookup_signal_reg;
  assign bus.lookup_sugar  = lookup_sugar_reg;
  assign bus.render_signal = render_signal_reg;
  assign bus.render_sugar  = render_sugar_reg;
  assign bus.decay_busy    = busy_reg;
  assign bus.sweep_done    = done_reg;

endmodule
